// File: rtl/gs_pkg.sv
// Shared Goldschmidt divider / verifier definitions.
// Q2.FRAC fixed-point constants and the verifier FSM state type.
package gs_pkg;

    localparam int GS_WIDTH = 30;
    localparam int FRAC = GS_WIDTH - 2;
    localparam logic [GS_WIDTH-1:0] ONE = GS_WIDTH'(1) << FRAC;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        CMP,
        DONE
    } gs_vstate_t;

endpackage

// File: rtl/goldschmidt_verify_if.sv
// Operand/result handshake bundle for the Goldschmidt result checker.
// slave = checker side, master = producer/consumer side.
interface goldschmidt_verify_if #(
    parameter int WIDTH = 30
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] numerator;
    logic [WIDTH-1:0] denominator;
    logic [WIDTH-1:0] quotient;
    logic             out_valid;
    logic             out_ready;
    logic             pass;
    logic             div0;
    logic [WIDTH+2:0] residual;
    logic [7:0]       err_count;

    modport slave (
        input  in_valid, numerator, denominator, quotient, out_ready,
        output in_ready, out_valid, pass, div0, residual, err_count
    );

    modport master (
        output in_valid, numerator, denominator, quotient, out_ready,
        input  in_ready, out_valid, pass, div0, residual, err_count
    );
endinterface

// File: rtl/goldschmidt_verify_shift_add_mult.sv
// Radix-2 sequential shift-add multiplier: one partial product per cycle.
// start loads the operands; done is high during the last accumulate cycle.
module shift_add_mult #(
    parameter int WIDTH = 30
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [2*WIDTH-1:0] b_sh_q, b_sh_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;

    assign done = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign prod = acc_q;

    always_comb begin
        a_sh_d = a_sh_q;
        b_sh_d = b_sh_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start) begin
            a_sh_d = a;
            b_sh_d = {{WIDTH{1'b0}}, b};
            acc_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (a_sh_q[0])
                acc_d = acc_q + b_sh_q;
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q << 1;
            cnt_d  = cnt_q + CW'(1);
            if (done)
                busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh_q <= '0;
            b_sh_q <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            a_sh_q <= a_sh_d;
            b_sh_q <= b_sh_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end
endmodule

// File: rtl/goldschmidt_verify.sv
// In-line divider result checker: r = n - (q*d >> FRAC), pass when |r| <= TOL.
// Define GS_VERIFY_ERRCNT_EN to build the saturating failure counter.
module goldschmidt_verify
    import gs_pkg::*;
#(
    parameter int WIDTH = 30,
    parameter int TOL   = 4
) (
    input logic                clk,
    input logic                reset,
    goldschmidt_verify_if.slave bus
);
    localparam int FW = WIDTH - 2;
    localparam int RW = WIDTH + 3;
    localparam logic signed [RW-1:0] TOL_HI = RW'(TOL);
    localparam logic signed [RW-1:0] TOL_LO = RW'(-TOL);

    gs_vstate_t state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic             d0_q, d0_d;
    logic             pass_q, pass_d;
    logic             div0_q, div0_d;
    logic             vld_q, vld_d;
    logic [RW-1:0]    res_q, res_d;

    logic               start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic signed [RW-1:0] r_calc;
    logic               cmp_pass;

    shift_add_mult #(.WIDTH(WIDTH)) u_mult (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (bus.quotient),
        .b     (bus.denominator),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    // p is the truncated Q2.FRAC product, WIDTH+2 bits wide
    assign r_calc   = {3'b000, n_q} - RW'(mul_prod >> FW);
    assign cmp_pass = !d0_q && (r_calc <= TOL_HI) && (r_calc >= TOL_LO);

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        d0_d    = d0_q;
        pass_d  = pass_q;
        div0_d  = div0_q;
        res_d   = res_q;
        vld_d   = vld_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    n_d  = bus.numerator;
                    d0_d = (bus.denominator == '0);
                    if (d0_d) begin
                        state_d = CMP;
                    end else begin
                        start   = 1'b1;
                        state_d = MUL;
                    end
                end
            end
            MUL: begin
                if (mul_done)
                    state_d = CMP;
            end
            CMP: begin
                pass_d  = cmp_pass;
                div0_d  = d0_q;
                res_d   = d0_q ? {3'b000, n_q} : r_calc;
                state_d = DONE;
            end
            DONE: begin
                if (vld_q && bus.out_ready) begin
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    vld_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            n_q     <= '0;
            d0_q    <= 1'b0;
            pass_q  <= 1'b0;
            div0_q  <= 1'b0;
            res_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            d0_q    <= d0_d;
            pass_q  <= pass_d;
            div0_q  <= div0_d;
            res_q   <= res_d;
            vld_q   <= vld_d;
        end
    end

`ifdef GS_VERIFY_ERRCNT_EN
    logic [7:0] errc_q, errc_d;

    always_comb begin
        errc_d = errc_q;
        if (state_q == CMP && !cmp_pass && errc_q != 8'hFF)
            errc_d = errc_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            errc_q <= '0;
        else
            errc_q <= errc_d;
    end

    assign bus.err_count = errc_q;
`else
    assign bus.err_count = 8'd0;
`endif

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = vld_q;
    assign bus.pass      = pass_q;
    assign bus.div0      = div0_q;
    assign bus.residual  = res_q;
endmodule
